cla_wide_seq: RTL and testbench

CLA_WIDE_SEQ -- requirements
Module: cla_wide_seq

---
 rtl/cla_wide_seq.sv | 160 ++++++++++++++++
 tb/tb_cla_wide_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cla_wide_seq.sv
// Sequential wide adder that reuses a single 16-bit carry-lookahead adder.
// It processes one 16-bit slice per cycle, starting from the least significant slice.

module cla_16b (
  input  logic        CI,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        CO,
  output logic [15:0] S
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    gp = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    // Group carries are fully expanded, so no carry ripples between groups.
    gc[0] = CI;
    gc[1] = gg[0] | (gp[0] & CI);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & CI);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & CI);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & CI);
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
    S  = p ^ c;
    CO = gc[4];
  end
endmodule

module cla_wide_seq #(
  parameter int NSLICE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*NSLICE-1:0]   A,
  input  logic [16*NSLICE-1:0]   B,
  input  logic                   CI,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NSLICE-1:0]   S,
  output logic                   CO,
  output logic                   OV,
  output logic                   busy
);
  localparam int W  = 16 * NSLICE;
  localparam int IW = $clog2(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   cy_q, cy_d;
  logic [W-1:0]           s_q, s_d;
  logic                   co_q, co_d;
  logic                   ov_q, ov_d;
  logic signed [W-1:0]    a_q, a_d, b_q, b_d;

  logic [15:0] add_a, add_b, add_s;
  logic        add_co;

  assign add_a = a_q[16*idx_q +: 16];
  assign add_b = b_q[16*idx_q +: 16];

  cla_16b u_cla (
    .CI (cy_q),
    .A  (add_a),
    .B  (add_b),
    .CO (add_co),
    .S  (add_s)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    a_d     = a_q;
    b_d     = b_q;
    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_d     = A;
          b_d     = B;
          cy_d    = CI;
          idx_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          s_d[16*idx_q +: 16] = add_s;
          cy_d  = add_co;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            // The final slice's sum MSB is the result sign bit.
            co_d    = add_co;
            ov_d    = (a_q[W-1] == b_q[W-1]) && (add_s[15] != a_q[W-1]);
            idx_d   = '0;
            state_d = DONE;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  // Operand holding registers are pure data and carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign S         = s_q;
  assign CO        = co_q;
  assign OV        = ov_q;
endmodule

// File: tb/tb_cla_wide_seq.sv
// Directed bench for cla_wide_seq with NSLICE=4, using hand-computed sums.
`timescale 1ns/1ps
module tb_cla_wide_seq;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready, CI, out_valid, out_ready, CO, OV, busy;
  logic [W-1:0] A, B, S;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_wide_seq #(.NSLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CI(CI), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .CO(CO), .OV(OV), .busy(busy)
  );

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    A = a; B = b; CI = ci; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    lat--;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    start_op(a, b, ci);
    wait_done(lat);
    checks++;
    if (lat != 4 || out_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency got %0d valid %b want 4 valid 1", name, lat, out_valid);
    end
    checks++;
    if (S !== es) begin errors++; $display("FAIL %s S got %h want %h", name, S, es); end
    checks++;
    if (CO !== eco) begin errors++; $display("FAIL %s CO got %b want %b", name, CO, eco); end
    checks++;
    if (OV !== eov) begin errors++; $display("FAIL %s OV got %b want %b", name, OV, eov); end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s busy/in_ready got %b/%b want 1/0", name, busy, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s release got ov/ir/busy %b%b%b want 010", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; CI = 1'b0;
    #12;
    checks++;
    if (S !== '0 || CO !== 1'b0 || OV !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got S=%h CO=%b OV=%b want 0", S, CO, OV);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got ir/ov/busy %b%b%b want 100", in_ready, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    run_op("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("pos_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_negative();
    run_op("neg_sum", 64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFEC, 1'b1,
           64'hFFFF_FFFF_FFFF_FFD9, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("neg_overflow", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    run_op("mid_carry", 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    int lat;
    start_op(64'd5, 64'd7, 1'b0);
    wait_done(lat);
    A = 64'h1234; B = 64'h4321; CI = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || S !== 64'd12 || CO !== 1'b0 || OV !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold cycle %0d got ov=%b S=%h CO=%b OV=%b ir=%b want 1 12 0 0 0",
                           i, out_valid, S, CO, OV, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got ov/ir/busy %b%b%b want 010", out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || S !== 64'd12) begin
      errors++; $display("FAIL hold_no_capture got busy=%b S=%h want 0 12", busy, S);
    end
  endtask

  task automatic test_clr();
    logic seen;
    start_op(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_idle got ir/busy/ov %b%b%b want 100", in_ready, busy, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL clr_no_valid got out_valid seen 1 want 0"); end
    run_op("after_clr", 64'd444, 64'd666, 1'b1, 64'd1111, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    start_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (S !== '0 || CO !== 1'b0 || OV !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got S=%h CO=%b OV=%b ir=%b ov=%b busy=%b want zeros ir=1",
                         S, CO, OV, in_ready, out_valid, busy);
    end
    #1 rst_n = 1'b1;
    run_op("after_reset", 64'd30000, 64'd2767, 1'b0, 64'd32767, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_negative();
    test_back_to_back();
    test_hold();
    test_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
